// File: rtl/bmp_frame_packer.sv
// Purpose: buffers an RGB frame (R/G/B planes) and streams it out as a 24-bit BMP byte stream.
// Latency: first header byte valid the cycle after the in_done rise, then one byte per cycle.
// Backpressure: out_valid/out_ready; out_byte held while stalled, pixel reads prefetched so no bubbles.
module bmp_frame_packer #(
    parameter int MAX_WIDTH  = 1080,
    parameter int MAX_HEIGHT = 1080
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [7:0]  in_r,
    input  logic [7:0]  in_g,
    input  logic [7:0]  in_b,
    input  logic [10:0] in_row,
    input  logic [10:0] in_col,
    input  logic [31:0] in_width,
    input  logic [31:0] in_height,
    input  logic        in_valid,
    input  logic        in_done,
    output logic [7:0]  out_byte,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        frame_done,
    output logic        err
);
    localparam int          DEPTH = MAX_WIDTH * MAX_HEIGHT;
    localparam int          AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] MAXW  = 32'(MAX_WIDTH);
    localparam logic [31:0] MAXH  = 32'(MAX_HEIGHT);

    typedef enum logic [2:0] {IDLE, HEADER, PIXEL, PAD, FIN} state_t;

    state_t      state, state_n;
    logic [5:0]  idx, idx_n;       // header byte index, reused as pad byte counter
    logic [10:0] row, row_n;
    logic [10:0] col, col_n;
    logic [1:0]  comp, comp_n;     // 0=B, 1=G, 2=R
    logic [31:0] w_q, h_q, s_q;
    logic [1:0]  p_q;
    logic        done_q;
    logic        done_rise;
    logic        adv;
    logic        load;
    logic        fin_n;
    logic [7:0]  gen_byte;

    logic [7:0]  mem_r [DEPTH];
    logic [7:0]  mem_g [DEPTH];
    logic [7:0]  mem_b [DEPTH];
    logic [7:0]  rd_r, rd_g, rd_b;

    logic          wr_oob;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic [31:0]   w3;
    logic [1:0]    lat_p;
    logic [31:0]   lat_s;
    logic          bad_dims;
    logic          start;

    assign done_rise = in_done & ~done_q;
    assign adv       = ~out_valid | out_ready;
    assign busy      = (state != IDLE);
    assign wr_oob    = (32'(in_row) >= MAXH) || (32'(in_col) >= MAXW);
    assign wr_addr   = AW'(32'(in_row) * MAXW + 32'(in_col));
    // Address of the pixel the generator will point at after this edge, so data is ready in time.
    assign rd_addr   = AW'(32'(row_n) * MAXW + 32'(col_n));
    assign w3        = in_width + {in_width[30:0], 1'b0};
    assign lat_p     = 2'd0 - w3[1:0];
    assign lat_s     = (w3 + 32'(lat_p)) * in_height;
    assign bad_dims  = (in_width == 32'd0) || (in_height == 32'd0) || (in_width > MAXW) || (in_height > MAXH);
    assign start     = (state == IDLE) && done_rise && !bad_dims;

    function automatic logic [7:0] hdr_at(input logic [5:0] i, input logic [31:0] w,
                                          input logic [31:0] h, input logic [31:0] s);
        logic [31:0] f;
        logic [1:0]  k;
        f = 32'd0;
        k = i[1:0] - 2'd2;   // every 4-byte field starts at an index = 2 mod 4
        if      (i < 6'd6)  f = 32'd54 + s;
        else if (i < 6'd10) f = 32'd0;
        else if (i < 6'd14) f = 32'd54;
        else if (i < 6'd18) f = 32'd40;
        else if (i < 6'd22) f = w;
        else if (i < 6'd26) f = h;
        else if (i < 6'd34) f = 32'd0;
        else if (i < 6'd38) f = s;
        else                f = 32'd0;
        if      (i == 6'd0)  hdr_at = 8'h42;
        else if (i == 6'd1)  hdr_at = 8'h4D;
        else if (i == 6'd26) hdr_at = 8'd1;
        else if (i == 6'd28) hdr_at = 8'd24;
        else if (i == 6'd27 || i == 6'd29) hdr_at = 8'd0;
        else                 hdr_at = f[{k, 3'b000} +: 8];
    endfunction

    // Frame buffer writes (IDLE only) and registered prefetch read.
    always_ff @(posedge CLK) begin
        if (state == IDLE && in_valid && !wr_oob) begin
            mem_r[wr_addr] <= in_r;
            mem_g[wr_addr] <= in_g;
            mem_b[wr_addr] <= in_b;
        end
        rd_r <= mem_r[rd_addr];
        rd_g <= mem_g[rd_addr];
        rd_b <= mem_b[rd_addr];
    end

    // State and generator position registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
            idx   <= 6'd0;
            row   <= 11'd0;
            col   <= 11'd0;
            comp  <= 2'd0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            row   <= row_n;
            col   <= col_n;
            comp  <= comp_n;
        end
    end

    // Next-state and next-byte generation; a byte is loaded whenever the output register frees up.
    always_comb begin
        state_n  = state;
        idx_n    = idx;
        row_n    = row;
        col_n    = col;
        comp_n   = comp;
        load     = 1'b0;
        fin_n    = 1'b0;
        gen_byte = 8'h00;
        case (state)
            IDLE: if (start) begin
                state_n  = HEADER;
                idx_n    = 6'd1;
                load     = 1'b1;
                gen_byte = 8'h42;
            end
            HEADER: if (adv) begin
                load     = 1'b1;
                gen_byte = hdr_at(idx, w_q, h_q, s_q);
                if (idx == 6'd53) begin
                    state_n = PIXEL;
                    row_n   = h_q[10:0] - 11'd1;
                    col_n   = 11'd0;
                    comp_n  = 2'd0;
                end else begin
                    idx_n = idx + 6'd1;
                end
            end
            PIXEL: if (adv) begin
                load     = 1'b1;
                gen_byte = (comp == 2'd0) ? rd_b : (comp == 2'd1) ? rd_g : rd_r;
                if (comp != 2'd2) begin
                    comp_n = comp + 2'd1;
                end else begin
                    comp_n = 2'd0;
                    if (col != w_q[10:0] - 11'd1) begin
                        col_n = col + 11'd1;
                    end else begin
                        col_n = 11'd0;
                        if (p_q != 2'd0) begin
                            state_n = PAD;
                            idx_n   = 6'd0;
                        end else if (row == 11'd0) begin
                            state_n = FIN;
                        end else begin
                            row_n = row - 11'd1;
                        end
                    end
                end
            end
            PAD: if (adv) begin
                load = 1'b1;
                if (idx[1:0] != p_q - 2'd1) begin
                    idx_n = idx + 6'd1;
                end else if (row == 11'd0) begin
                    state_n = FIN;
                end else begin
                    state_n = PIXEL;
                    row_n   = row - 11'd1;
                end
            end
            FIN: if (out_valid && out_ready) begin
                state_n = IDLE;
                fin_n   = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    // Output register, frame parameter latch, edge detector and sticky error.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            out_byte   <= 8'h00;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
            done_q     <= 1'b0;
            w_q        <= 32'd0;
            h_q        <= 32'd0;
            s_q        <= 32'd0;
            p_q        <= 2'd0;
        end else begin
            done_q     <= in_done;
            frame_done <= fin_n;
            if (load) begin
                out_byte  <= gen_byte;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (start) begin
                w_q <= in_width;
                h_q <= in_height;
                s_q <= lat_s;
                p_q <= lat_p;
            end
            if (state == IDLE && ((in_valid && wr_oob) || (done_rise && bad_dims)))
                err <= 1'b1;
        end
    end
endmodule
